muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 206 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit, one radix-2 step per cycle.
//   Multiply: shift-add on operand magnitudes. Divide: restoring shift-subtract.
//   Sign fixup and the special cases (divide by zero, signed overflow) are
//   applied in the FIN state.
// Optional feature (macro MULDIV_EARLY_OUT_EN): when it is defined, divide by
//   zero, signed overflow and multiply by a zero operand skip CALC, giving a
//   latency of 2. When it is undefined, every operation takes WIDTH+1 cycles.
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   start  - request, sampled only while ready=1
//   op     - RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   SrcA   - rs1 operand (multiplicand / dividend)
//   SrcB   - rs2 operand (multiplier / divisor)
//   ready  - high when a new start is accepted
//   busy   - high while an operation is in progress
//   done   - one-cycle pulse, Result valid
//   Result - result, held until the next accepted start
module muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Result
);

   localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
   localparam logic [WIDTH:0]   ZERO_W1  = {(WIDTH+1){1'b0}};
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_e;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] a_q;        // |SrcA|, added in each multiply step
   logic [WIDTH-1:0] b_q;        // |SrcB|, divisor
   logic [WIDTH-1:0] acc_q;      // product high half / partial remainder
   logic [WIDTH-1:0] lo_q;       // multiplier -> product low half / dividend -> quotient
   logic             neg_a_q;
   logic             neg_b_q;
   logic             spec_q;
   logic [WIDTH-1:0] spec_val_q;
`ifdef MULDIV_EARLY_OUT_EN
   logic             hold_q;     // pads the early-out path to a 2-cycle latency
`endif

   // Operand decode at acceptance: signedness, magnitudes, special cases
   logic             a_sgn, b_sgn, neg_a, neg_b, div0, ovf, mul0, spec;
   logic [WIDTH-1:0] mag_a, mag_b, spec_val;

   always_comb begin
      a_sgn = 1'b0;
      b_sgn = 1'b0;
      case (op)
         3'b000, 3'b001, 3'b100, 3'b110: begin
            a_sgn = 1'b1;
            b_sgn = 1'b1;
         end
         3'b010:  a_sgn = 1'b1;
         default: ;
      endcase
      neg_a    = a_sgn & SrcA[WIDTH-1];
      neg_b    = b_sgn & SrcB[WIDTH-1];
      mag_a    = neg_a ? -SrcA : SrcA;
      mag_b    = neg_b ? -SrcB : SrcB;
      div0     = op[2] && (SrcB == ZERO_W);
      ovf      = op[2] && !op[0] && (SrcA == MOST_NEG) && (SrcB == ALL_ONES);
      mul0     = !op[2] && ((SrcA == ZERO_W) || (SrcB == ZERO_W));
      spec     = div0 | ovf | mul0;
      spec_val = ZERO_W;
      if (div0) begin
         spec_val = op[1] ? SrcA : ALL_ONES;
      end else if (ovf) begin
         spec_val = op[1] ? ZERO_W : MOST_NEG;
      end
   end

   // One radix-2 iteration (shift-add or restoring shift-subtract)
   logic [WIDTH:0]   mul_sum, div_sh, div_diff;
   logic             div_ge;
   logic [WIDTH-1:0] acc_d, lo_d;

   always_comb begin
      mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, a_q} : ZERO_W1);
      div_sh   = {acc_q, lo_q[WIDTH-1]};
      div_diff = div_sh - {1'b0, b_q};
      div_ge   = (div_sh >= {1'b0, b_q});
      acc_d    = mul_sum[WIDTH:1];
      lo_d     = {mul_sum[0], lo_q[WIDTH-1:1]};
      if (op_q[2]) begin
         acc_d = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
         lo_d  = {lo_q[WIDTH-2:0], div_ge};
      end
   end

   // Sign fixup and result selection
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix, res_fix;

   always_comb begin
      prod     = {acc_q, lo_q};
      prod_fix = (neg_a_q ^ neg_b_q) ? -prod : prod;
      quo_fix  = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
      rem_fix  = neg_a_q ? -acc_q : acc_q;
      res_fix  = rem_fix;
      case (op_q)
         3'b000:                 res_fix = prod_fix[WIDTH-1:0];
         3'b001, 3'b010, 3'b011: res_fix = prod_fix[2*WIDTH-1:WIDTH];
         3'b100, 3'b101:         res_fix = quo_fix;
         default:                res_fix = rem_fix;
      endcase
      if (spec_q) begin
         res_fix = spec_val_q;
      end
   end

   // Control FSM and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         acc_q      <= '0;
         lo_q       <= '0;
         neg_a_q    <= 1'b0;
         neg_b_q    <= 1'b0;
         spec_q     <= 1'b0;
         spec_val_q <= '0;
`ifdef MULDIV_EARLY_OUT_EN
         hold_q     <= 1'b0;
`endif
         ready      <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         Result     <= '0;
      end else begin
         done <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  op_q       <= op;
                  a_q        <= mag_a;
                  b_q        <= mag_b;
                  acc_q      <= '0;
                  lo_q       <= op[2] ? mag_a : mag_b;
                  neg_a_q    <= neg_a;
                  neg_b_q    <= neg_b;
                  spec_q     <= spec;
                  spec_val_q <= spec_val;
                  cnt_q      <= CNT_LOAD;
                  ready      <= 1'b0;
                  busy       <= 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
                  if (spec) begin
                     state_q <= FIN;
                     hold_q  <= 1'b1;
                  end else begin
                     state_q <= CALC;
                  end
`else
                  state_q    <= CALC;
`endif
               end
            end
            CALC: begin
               acc_q <= acc_d;
               lo_q  <= lo_d;
               cnt_q <= cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  state_q <= FIN;
               end
            end
            FIN: begin
`ifdef MULDIV_EARLY_OUT_EN
               if (hold_q) begin
                  hold_q <= 1'b0;
               end else
`endif
               begin
                  Result  <= res_fix;
                  done    <= 1'b1;
                  ready   <= 1'b1;
                  busy    <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: a 32-bit and an 8-bit instance, directed
// cases plus random operations checked against a longint arithmetic model.
module tb_muldiv_unit;

   typedef struct {
      logic [31:0] res;
      int          acc;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;

   logic        start32 = 1'b0;
   logic [2:0]  op32 = '0;
   logic [31:0] a32 = '0, b32 = '0;
   logic        ready32, busy32, done32;
   logic [31:0] res32;

   logic        start8 = 1'b0;
   logic [2:0]  op8 = '0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        ready8, busy8, done8;
   logic [7:0]  res8;

   exp_t q32[$];
   exp_t q8[$];

   muldiv_unit #(.WIDTH(32)) u_dut32 (
      .clk(clk), .rst(rst), .start(start32), .op(op32), .SrcA(a32), .SrcB(b32),
      .ready(ready32), .busy(busy32), .done(done32), .Result(res32)
   );

   muldiv_unit #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .op(op8), .SrcA(a8), .SrcB(b8),
      .ready(ready8), .busy(busy8), .done(done8), .Result(res8)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: RV32M semantics on w-bit operands using 64-bit arithmetic
   function automatic logic [31:0] model(input int w, input logic [2:0] op,
                                         input longint unsigned a, input longint unsigned b);
      longint unsigned mask, r;
      longint          sa, sb, p;
      mask = (longint'(1) << w) - 1;
      sa   = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
      sb   = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
      r    = 0;
      case (op)
         3'd0: begin p = sa * sb; r = p; end
         3'd1: begin p = sa * sb; p = p >>> w; r = p; end
         3'd2: begin p = sa * longint'(b); p = p >>> w; r = p; end
         3'd3: r = (a * b) >> w;
         3'd4: if (b == 0) r = mask; else begin p = sa / sb; r = p; end
         3'd5: if (b == 0) r = mask; else r = a / b;
         3'd6: if (b == 0) r = a; else begin p = sa % sb; r = p; end
         default: if (b == 0) r = a; else r = a % b;
      endcase
      return 32'(r & mask);
   endfunction

   function automatic int lat_of(input int w, input logic [2:0] op,
                                 input longint unsigned a, input longint unsigned b);
      longint unsigned ones, mn;
      bit early;
      ones  = (longint'(1) << w) - 1;
      mn    = longint'(1) << (w - 1);
      early = (op[2] && b == 0) || ((op == 3'd4 || op == 3'd6) && a == mn && b == ones) ||
              (!op[2] && (a == 0 || b == 0));
`ifdef MULDIV_EARLY_OUT_EN
      if (early) return 2;
`endif
      return early ? w + 1 : w + 1;
   endfunction

   function automatic longint unsigned pick(input int w);
      longint unsigned mask;
      mask = (longint'(1) << w) - 1;
      case ($urandom_range(0, 6))
         0:       return 0;
         1:       return mask;
         2:       return longint'(1) << (w - 1);
         3:       return longint'($urandom_range(0, 9));
         default: return longint'($urandom) & mask;
      endcase
   endfunction

   // Drivers: called at posedge+1; issue when ready, push expectation after acceptance
   task automatic issue32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
      int n = 0;
      while (!ready32 && n < 200) begin
         @(posedge clk); #1; n++;
      end
      check("issue32_ready", 64'(ready32), 64'(1));
      op32 = op; a32 = a; b32 = b; start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0; op32 = 3'($urandom); a32 = $urandom; b32 = $urandom;
      q32.push_back('{res: exp, acc: cyc, lat: lat_of(32, op, longint'(a), longint'(b))});
   endtask

   task automatic issue8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp);
      int n = 0;
      while (!ready8 && n < 200) begin
         @(posedge clk); #1; n++;
      end
      check("issue8_ready", 64'(ready8), 64'(1));
      op8 = op; a8 = a; b8 = b; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0; op8 = 3'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
      q8.push_back('{res: 32'(exp), acc: cyc, lat: lat_of(8, op, longint'(a), longint'(b))});
   endtask

   task automatic drain();
      int n = 0;
      while ((q32.size() != 0 || q8.size() != 0) && n < 2000) begin
         @(posedge clk); #1; n++;
      end
      check("drain_pending", 64'(q32.size() + q8.size()), 64'(0));
   endtask

   // Monitors: pop and compare whenever a done pulse is seen
   always @(negedge clk) begin
      if (done32) begin
         if (q32.size() == 0) begin
            total++; bad++;
            $display("FAIL spurious_done32: got done=1 expected no done (Result=%0h)", res32);
         end else begin
            exp_t e;
            e = q32.pop_front();
            check("result32", 64'(res32), 64'(e.res));
            check("latency32", 64'(cyc - e.acc), 64'(e.lat));
         end
      end
      if (done8) begin
         if (q8.size() == 0) begin
            total++; bad++;
            $display("FAIL spurious_done8: got done=1 expected no done (Result=%0h)", res8);
         end else begin
            exp_t e;
            e = q8.pop_front();
            check("result8", 64'(res8), 64'(e.res));
            check("latency8", 64'(cyc - e.acc), 64'(e.lat));
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready32", 64'(ready32), 64'(1));
      check("rst_busy32", 64'(busy32), 64'(0));
      check("rst_done32", 64'(done32), 64'(0));
      check("rst_result32", 64'(res32), 64'(0));
      check("rst_ready8", 64'(ready8), 64'(1));
      check("rst_busy8", 64'(busy8), 64'(0));
      check("rst_result8", 64'(res8), 64'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      // Multiply / divide directed values
      issue32(3'd0, 32'd6, 32'd4, 32'd24);
      check("busy_in_calc32", 64'(busy32), 64'(1));
      issue32(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
      issue32(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      issue32(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      issue32(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      issue32(3'd5, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC);
      // Divide by zero and signed overflow
      issue32(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
      issue32(3'd7, 32'd5, 32'd0, 32'd5);
      issue32(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      issue32(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
      issue32(3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
      issue32(3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
      issue32(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      drain();

      // start while busy is ignored
      issue32(3'd0, 32'd3, 32'd5, 32'd15);
      repeat (8) @(posedge clk);
      #1;
      op32 = 3'd4; a32 = 32'd9; b32 = 32'd3; start32 = 1'b1;
      check("ready_low_while_busy32", 64'(ready32), 64'(0));
      @(posedge clk); #1;
      start32 = 1'b0;
      drain();
      repeat (40) @(posedge clk);
      #1;

      // Reset mid-operation aborts without a done pulse
      issue32(3'd4, 32'd100, 32'd7, 32'd14);
      void'(q32.pop_back());
      repeat (10) @(posedge clk);
      #1;
      check("pre_rst_busy32", 64'(busy32), 64'(1));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_busy32", 64'(busy32), 64'(0));
      check("abort_ready32", 64'(ready32), 64'(1));
      check("abort_done32", 64'(done32), 64'(0));
      check("abort_result32", 64'(res32), 64'(0));
      repeat (40) @(posedge clk);
      #1;
      issue32(3'd4, 32'd100, 32'd7, 32'd14);
      drain();

      // Narrow instance, then Result must hold after done
      issue8(3'd2, 8'hFF, 8'hFF, 8'hFF);
      drain();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_result8", 64'(res8), 64'(8'hFF));
         check("hold_done8", 64'(done8), 64'(0));
      end
      @(posedge clk); #1;
      issue8(3'd4, 8'h80, 8'hFF, 8'h80);
      issue8(3'd7, 8'd200, 8'd0, 8'd200);
      issue8(3'd6, 8'hF9, 8'd2, 8'hFF);

      // Random operations, issued back-to-back
      for (int i = 0; i < 40; i++) begin
         logic [2:0] op;
         longint unsigned a, b;
         op = 3'($urandom_range(0, 7));
         a  = pick(32);
         b  = pick(32);
         issue32(op, 32'(a), 32'(b), model(32, op, a, b));
      end
      for (int i = 0; i < 60; i++) begin
         logic [2:0] op;
         longint unsigned a, b;
         op = 3'($urandom_range(0, 7));
         a  = pick(8);
         b  = pick(8);
         issue8(op, 8'(a), 8'(b), 8'(model(8, op, a, b)));
      end
      drain();
      repeat (40) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
